tensaurus_fetch_ctrl: RTL and testbench
=======================================

Name: tensaurus_fetch_ctrl

Overview:
Sequencer that walks a compressed-row (CSR-style) sparse slice in on-chip memory and emits the coordinate beat stream consumed by the tensaurus coordinate decoder. Each non-empty row produces one header beat (nnz_addr = 0, i_or_j = row index), then one beat per nonzero (nnz_addr = nonzero address, i_or_j = j, k = k). The block reads a row-pointer memory and a nonzero memory, both single-port with 1-cycle read latency, and drives the downstream stream through a valid/ready handshake.

Parameters:
MEMORY_ADDRESS_SIZE, 10, width of pointer values and nonzero-memory addresses
INDEX_SIZE, 8, width of the i/j/k indices; the row count field is INDEX_SIZE+1 bits wide

Ports:
clk  in  1  clock; all logic on the rising edge
rst  in  1  asynchronous, active-low reset (0 = reset)
start  in  1  one-cycle pulse that begins a traversal; ignored while busy=1
num_rows  in  INDEX_SIZE+1  row count; sampled on the accepted start
ptr_rd_en  out  1  row-pointer memory read strobe
ptr_rd_addr  out  INDEX_SIZE+1  row-pointer address
ptr_rd_data  in  MEMORY_ADDRESS_SIZE  pointer value; valid the cycle after ptr_rd_en
nz_rd_en  out  1  nonzero memory read strobe
nz_rd_addr  out  MEMORY_ADDRESS_SIZE  nonzero address
nz_rd_data  in  2*INDEX_SIZE  {j, k}, j in the upper half; valid the cycle after nz_rd_en
out_valid  out  1  stream beat valid
out_ready  in  1  downstream accept
out_nnz_addr  out  MEMORY_ADDRESS_SIZE  0 for a header beat, otherwise the nonzero address
out_i_or_j  out  INDEX_SIZE  row index (header beat) or j (nonzero beat)
out_k  out  INDEX_SIZE  k (nonzero beat); 0 on header beats
busy  out  1  traversal in progress
done  out  1  one-cycle pulse at the end of a traversal
err  out  1  sticky malformed-pointer flag; cleared by the next accepted start

Behaviour:
- Reset (rst=0, asynchronous): FSM goes to IDLE. Every output is 0: out_valid, busy, done, err, both read enables, all address and data outputs.
- Memory format: ptr[r] is the first nonzero address of row r and ptr[r+1] is one past the last. Nonzero address 0 is reserved for the header encoding, so a valid ptr is >= 1.
- FSM states: IDLE, P_FIRST, P_NEXT, P_WAIT, HDR, NZ_RD, NZ_OUT, FIN.
- IDLE: on start=1, latch num_rows, set r=0, busy=1, clear err.
  - If num_rows=0, go directly to FIN with no memory reads.
  - Otherwise go to P_FIRST.
- P_FIRST: ptr_rd_en=1, ptr_rd_addr=0; go to P_NEXT.
- P_NEXT: latch cur=ptr_rd_data. Issue a read of ptr[r+1]; go to P_WAIT.
- P_WAIT: latch end=ptr_rd_data. Then:
  - err condition (end < cur, or cur = 0) -> err=1, go to FIN.
  - end = cur (empty row) -> no beats; take the row advance.
  - otherwise -> go to HDR.
- HDR: out_valid=1, out_nnz_addr=0, out_i_or_j=r[INDEX_SIZE-1:0], out_k=0. Hold all values while out_ready=0. On valid&&ready, go to NZ_RD.
- NZ_RD: nz_rd_en=1, nz_rd_addr=cur; go to NZ_OUT.
- NZ_OUT: present out_nnz_addr=cur, out_i_or_j=j, out_k=k, with j and k registered from nz_rd_data on state entry. Output is stable until accepted. On valid&&ready:
  - cur+1 = end -> row advance.
  - otherwise cur <= cur+1, go to NZ_RD.
- Row advance:
  - If r+1 = num_rows, go to FIN.
  - Otherwise r <= r+1, cur <= end (the pointer is reused, not re-read), issue a read of ptr[r+2], go to P_WAIT.
- FIN: done=1 for exactly one cycle, busy=0 on the next cycle, return to IDLE.
- Throughput: one nonzero beat per 2 cycles with out_ready held high. Header cost is 1 cycle plus 2 cycles of pointer fetch per row.
- out_valid never drops before acceptance. Payload is constant while out_valid=1 and out_ready=0.
- A start pulse while busy=1 has no effect, including a start in the same cycle as done.
- Reset asserted mid-traversal aborts immediately. No done pulse is produced and no beat is completed.
- Arithmetic wraps at the declared widths. A pointer value of 2^MEMORY_ADDRESS_SIZE-1 is legal as end.

Test Plan:
- Reset with start held high -> all outputs 0; after release, only a new start pulse begins a traversal.
- num_rows=2, ptr={1,3,4}, nz[1]={5,6}, nz[2]={7,8}, nz[3]={9,1}, out_ready=1 -> beats (0,0,0),(1,5,6),(2,7,8),(0,1,0),(3,9,1); done pulses once; err=0.
- num_rows=3, ptr={1,1,2,2} (rows 0 and 2 empty) -> beats (0,1,0),(1,nz[1]) only; done=1.
- Same stream as the first traversal scenario with out_ready toggling 0/1 every cycle -> identical beat sequence; payload stable while stalled.
- ptr={4,2} with num_rows=1 -> no beats, err=1, done pulses; the next start clears err.
- num_rows=0 -> done within 2 cycles, zero memory reads. Reset pulsed during NZ_OUT -> out_valid=0 immediately, FSM in IDLE.

Source files
------------

// File: rtl/tensaurus_fetch_ctrl_if.sv
// Memory-read and coordinate-stream bundle of the tensaurus fetch controller.
// master = the controller, slave = memories plus downstream consumer.
interface tensaurus_fetch_ctrl_if #(
    parameter int unsigned MEMORY_ADDRESS_SIZE = 10,
    parameter int unsigned INDEX_SIZE          = 8
);
    logic                           ptr_rd_en;
    logic [INDEX_SIZE:0]            ptr_rd_addr;
    logic [MEMORY_ADDRESS_SIZE-1:0] ptr_rd_data;

    logic                           nz_rd_en;
    logic [MEMORY_ADDRESS_SIZE-1:0] nz_rd_addr;
    logic [2*INDEX_SIZE-1:0]        nz_rd_data;

    logic                           out_valid;
    logic                           out_ready;
    logic [MEMORY_ADDRESS_SIZE-1:0] out_nnz_addr;
    logic [INDEX_SIZE-1:0]          out_i_or_j;
    logic [INDEX_SIZE-1:0]          out_k;

    modport master (
        output ptr_rd_en, ptr_rd_addr,
        input  ptr_rd_data,
        output nz_rd_en, nz_rd_addr,
        input  nz_rd_data,
        output out_valid, out_nnz_addr, out_i_or_j, out_k,
        input  out_ready
    );

    modport slave (
        input  ptr_rd_en, ptr_rd_addr,
        output ptr_rd_data,
        input  nz_rd_en, nz_rd_addr,
        output nz_rd_data,
        input  out_valid, out_nnz_addr, out_i_or_j, out_k,
        output out_ready
    );
endinterface

// File: rtl/tensaurus_fetch_ctrl.sv
// Walks a CSR sparse slice (row pointers + {j,k} nonzeros) and emits the
// header/nonzero coordinate beat stream for the tensaurus decoder.
module tensaurus_fetch_ctrl #(
    parameter int unsigned MEMORY_ADDRESS_SIZE = 10,
    parameter int unsigned INDEX_SIZE          = 8
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  start_i,
    input  logic [INDEX_SIZE:0]   num_rows_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  err_o,
    tensaurus_fetch_ctrl_if.master bus
);
    localparam int unsigned RW = INDEX_SIZE + 1;
    localparam int unsigned MW = MEMORY_ADDRESS_SIZE;
    localparam int unsigned IW = INDEX_SIZE;

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_P_FIRST = 3'd1;
    localparam logic [2:0] S_P_NEXT  = 3'd2;
    localparam logic [2:0] S_P_WAIT  = 3'd3;
    localparam logic [2:0] S_HDR     = 3'd4;
    localparam logic [2:0] S_NZ_RD   = 3'd5;
    localparam logic [2:0] S_NZ_OUT  = 3'd6;
    localparam logic [2:0] S_FIN     = 3'd7;

    logic [2:0]    state_q, state_d;
    logic [RW-1:0] rows_q, rows_d;
    logic [RW-1:0] r_q, r_d;
    logic [MW-1:0] cur_q, cur_d;
    logic [MW-1:0] end_q, end_d;
    logic [IW-1:0] j_q, j_d;
    logic [IW-1:0] k_q, k_d;
    logic          fresh_q, fresh_d;
    logic          err_q, err_d;

    logic          ptr_en;
    logic [RW-1:0] ptr_addr;
    logic          nz_en;
    logic [MW-1:0] nz_addr;

    logic [RW-1:0] r_inc, r_inc2;
    logic [MW-1:0] cur_inc;
    logic [IW-1:0] nz_j, nz_k;
    logic [IW-1:0] pay_j, pay_k;
    logic          adv;
    logic [MW-1:0] adv_ptr;
    logic [MW-1:0] ptr_in;

    assign r_inc   = r_q + 1'b1;
    assign r_inc2  = r_q + 2'd2;
    assign cur_inc = cur_q + 1'b1;
    assign ptr_in  = bus.ptr_rd_data;
    assign nz_j    = bus.nz_rd_data[2*IW-1:IW];
    assign nz_k    = bus.nz_rd_data[IW-1:0];

    // Nonzero data arrives during the first NZ_OUT cycle; it is shown directly
    // then and held from the capture register for the rest of a stall.
    assign pay_j = fresh_q ? nz_j : j_q;
    assign pay_k = fresh_q ? nz_k : k_q;

    always_comb begin
        state_d  = state_q;
        rows_d   = rows_q;
        r_d      = r_q;
        cur_d    = cur_q;
        end_d    = end_q;
        j_d      = j_q;
        k_d      = k_q;
        fresh_d  = 1'b0;
        err_d    = err_q;
        ptr_en   = 1'b0;
        ptr_addr = '0;
        nz_en    = 1'b0;
        nz_addr  = '0;
        adv      = 1'b0;
        adv_ptr  = '0;

        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    rows_d  = num_rows_i;
                    r_d     = '0;
                    err_d   = 1'b0;
                    state_d = (num_rows_i == '0) ? S_FIN : S_P_FIRST;
                end
            end
            S_P_FIRST: begin
                ptr_en   = 1'b1;
                ptr_addr = '0;
                state_d  = S_P_NEXT;
            end
            S_P_NEXT: begin
                cur_d    = ptr_in;
                ptr_en   = 1'b1;
                ptr_addr = r_inc;
                state_d  = S_P_WAIT;
            end
            S_P_WAIT: begin
                end_d = ptr_in;
                if (cur_q == '0 || ptr_in < cur_q) begin
                    err_d   = 1'b1;
                    state_d = S_FIN;
                end else if (ptr_in == cur_q) begin
                    adv     = 1'b1;
                    adv_ptr = ptr_in;
                end else begin
                    state_d = S_HDR;
                end
            end
            S_HDR: begin
                if (bus.out_ready) state_d = S_NZ_RD;
            end
            S_NZ_RD: begin
                nz_en   = 1'b1;
                nz_addr = cur_q;
                fresh_d = 1'b1;
                state_d = S_NZ_OUT;
            end
            S_NZ_OUT: begin
                if (fresh_q) begin
                    j_d = nz_j;
                    k_d = nz_k;
                end
                if (bus.out_ready) begin
                    if (cur_inc == end_q) begin
                        adv     = 1'b1;
                        adv_ptr = end_q;
                    end else begin
                        cur_d   = cur_inc;
                        state_d = S_NZ_RD;
                    end
                end
            end
            S_FIN: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Row advance: the end pointer of this row is the start of the next,
        // so only ptr[r+2] needs fetching.
        if (adv) begin
            if (r_inc == rows_q) begin
                state_d = S_FIN;
            end else begin
                r_d      = r_inc;
                cur_d    = adv_ptr;
                ptr_en   = 1'b1;
                ptr_addr = r_inc2;
                state_d  = S_P_WAIT;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= S_IDLE;
            rows_q  <= '0;
            r_q     <= '0;
            cur_q   <= '0;
            end_q   <= '0;
            j_q     <= '0;
            k_q     <= '0;
            fresh_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            rows_q  <= rows_d;
            r_q     <= r_d;
            cur_q   <= cur_d;
            end_q   <= end_d;
            j_q     <= j_d;
            k_q     <= k_d;
            fresh_q <= fresh_d;
            err_q   <= err_d;
        end
    end

    assign bus.ptr_rd_en    = ptr_en;
    assign bus.ptr_rd_addr  = ptr_addr;
    assign bus.nz_rd_en     = nz_en;
    assign bus.nz_rd_addr   = nz_addr;
    assign bus.out_valid    = (state_q == S_HDR) || (state_q == S_NZ_OUT);
    assign bus.out_nnz_addr = (state_q == S_NZ_OUT) ? cur_q : '0;
    assign bus.out_i_or_j   = (state_q == S_HDR)    ? r_q[IW-1:0] :
                              (state_q == S_NZ_OUT) ? pay_j : '0;
    assign bus.out_k        = (state_q == S_NZ_OUT) ? pay_k : '0;

    assign busy_o = (state_q != S_IDLE);
    assign done_o = (state_q == S_FIN);
    assign err_o  = err_q;
endmodule

// File: tb/tb_tensaurus_fetch_ctrl.sv
// Directed bench for tensaurus_fetch_ctrl: memory models, beat scoreboard,
// and reset/stall/error/abort scenarios.
module tb_tensaurus_fetch_ctrl;
    localparam int unsigned MAS = 10;
    localparam int unsigned IS  = 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic [IS:0]   num_rows;
    logic          busy, done, err;

    int            chk_cnt   = 0;
    int            pass_cnt  = 0;
    int            done_cnt  = 0;
    int            beats     = 0;
    int            ptr_reads = 0;
    int            nz_reads  = 0;

    logic [MAS-1:0]  ptr_mem [0:511];
    logic [2*IS-1:0] nz_mem  [0:1023];
    logic [25:0]     exp_q   [$];

    tensaurus_fetch_ctrl_if #(.MEMORY_ADDRESS_SIZE(MAS), .INDEX_SIZE(IS)) bus ();

    tensaurus_fetch_ctrl #(.MEMORY_ADDRESS_SIZE(MAS), .INDEX_SIZE(IS)) dut (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .start_i    (start),
        .num_rows_i (num_rows),
        .busy_o     (busy),
        .done_o     (done),
        .err_o      (err),
        .bus        (bus)
    );

    always #5 clk = ~clk;

    // Single-port memories with one cycle of read latency.
    always @(posedge clk) begin
        if (bus.ptr_rd_en) begin
            bus.ptr_rd_data <= ptr_mem[bus.ptr_rd_addr];
            ptr_reads       <= ptr_reads + 1;
        end
        if (bus.nz_rd_en) begin
            bus.nz_rd_data <= nz_mem[bus.nz_rd_addr];
            nz_reads       <= nz_reads + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        chk_cnt++;
        assert (obs === expv) pass_cnt++;
        else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
    endtask

    task automatic push(input logic [MAS-1:0] a, input logic [IS-1:0] ij, input logic [IS-1:0] k);
        exp_q.push_back({a, ij, k});
    endtask

    // Every presented beat must equal the scoreboard head, stalled or not.
    always @(negedge clk) begin
        if (done) done_cnt++;
        if (bus.out_valid) begin
            check("beat_expected", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                check("beat", 32'({bus.out_nnz_addr, bus.out_i_or_j, bus.out_k}), 32'(exp_q[0]));
                if (bus.out_ready) begin
                    void'(exp_q.pop_front());
                    beats++;
                end
            end
        end
    end

    task automatic pulse_start(input logic [IS:0] n);
        @(posedge clk); #1;
        start = 1'b1; num_rows = n;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget, input bit toggle, input string tag);
        int  base = done_cnt;
        bit  seen = 1'b0;
        for (int c = 0; c < budget && !seen; c++) begin
            @(posedge clk); #1;
            if (toggle) bus.out_ready = ~bus.out_ready;
            if (done_cnt != base) seen = 1'b1;
        end
        check(tag, 32'(seen), 32'd1);
    endtask

    task automatic load_s1();
        ptr_mem[0] = 10'd1; ptr_mem[1] = 10'd3; ptr_mem[2] = 10'd4;
        nz_mem[1] = {8'd5, 8'd6}; nz_mem[2] = {8'd7, 8'd8}; nz_mem[3] = {8'd9, 8'd1};
    endtask

    task automatic push_s1();
        push(10'd0, 8'd0, 8'd0); push(10'd1, 8'd5, 8'd6); push(10'd2, 8'd7, 8'd8);
        push(10'd0, 8'd1, 8'd0); push(10'd3, 8'd9, 8'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int base_done, base_ptr, base_nz, base_beats;
        bit found;

        // Reset with start held high
        rst_n = 1'b0; start = 1'b1; num_rows = 9'd5; bus.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy",  32'(busy), 32'd0);
        check("rst_done",  32'(done), 32'd0);
        check("rst_err",   32'(err), 32'd0);
        check("rst_valid", 32'(bus.out_valid), 32'd0);
        check("rst_rden",  32'({bus.ptr_rd_en, bus.nz_rd_en}), 32'd0);
        check("rst_addr",  32'({bus.ptr_rd_addr, bus.nz_rd_addr}), 32'd0);
        check("rst_pay",   32'({bus.out_nnz_addr, bus.out_i_or_j, bus.out_k}), 32'd0);
        start = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        check("idle_no_start_busy",  32'(busy), 32'd0);
        check("idle_no_start_reads", 32'(ptr_reads), 32'd0);

        // Two-row traversal, ready high, with starts while busy and at done
        load_s1(); push_s1();
        base_done = done_cnt;
        pulse_start(9'd2);
        repeat (2) @(posedge clk);
        #1; start = 1'b1; num_rows = 9'd7;
        @(posedge clk); #1; start = 1'b0;
        found = 1'b0;
        for (int c = 0; c < 100 && !found; c++) begin
            @(negedge clk);
            if (done) found = 1'b1;
        end
        check("s1_done_seen", 32'(found), 32'd1);
        start = 1'b1; num_rows = 9'd2;
        @(posedge clk); #1; start = 1'b0;
        base_ptr = ptr_reads;
        repeat (4) @(posedge clk);
        #1;
        check("s1_start_at_done_busy",  32'(busy), 32'd0);
        check("s1_start_at_done_reads", 32'(ptr_reads - base_ptr), 32'd0);
        check("s1_done_once", 32'(done_cnt - base_done), 32'd1);
        check("s1_err",       32'(err), 32'd0);
        check("s1_all_beats", 32'(exp_q.size()), 32'd0);
        check("s1_beat_count", 32'(beats), 32'd5);

        // Empty rows 0 and 2
        ptr_mem[0] = 10'd1; ptr_mem[1] = 10'd1; ptr_mem[2] = 10'd2; ptr_mem[3] = 10'd2;
        nz_mem[1] = {8'h11, 8'h22};
        push(10'd0, 8'd1, 8'd0); push(10'd1, 8'h11, 8'h22);
        base_done = done_cnt;
        pulse_start(9'd3);
        wait_done(100, 1'b0, "s2_done_seen");
        repeat (2) @(posedge clk);
        #1;
        check("s2_done_once", 32'(done_cnt - base_done), 32'd1);
        check("s2_all_beats", 32'(exp_q.size()), 32'd0);
        check("s2_err",       32'(err), 32'd0);

        // Same stream as the first traversal with ready toggling every cycle
        load_s1(); push_s1();
        base_beats = beats;
        pulse_start(9'd2);
        wait_done(200, 1'b1, "s3_done_seen");
        bus.out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("s3_all_beats",  32'(exp_q.size()), 32'd0);
        check("s3_beat_count", 32'(beats - base_beats), 32'd5);

        // Malformed pointers
        ptr_mem[0] = 10'd4; ptr_mem[1] = 10'd2;
        base_beats = beats; base_done = done_cnt;
        pulse_start(9'd1);
        wait_done(50, 1'b0, "s4_done_seen");
        #1;
        check("s4_err_set",   32'(err), 32'd1);
        check("s4_no_beats",  32'(beats - base_beats), 32'd0);
        check("s4_done_once", 32'(done_cnt - base_done), 32'd1);

        // Zero rows: clears err, done next cycle, no memory reads
        base_ptr = ptr_reads; base_nz = nz_reads;
        pulse_start(9'd0);
        check("s5_err_cleared", 32'(err), 32'd0);
        check("s5_done_fast",   32'(done), 32'd1);
        @(posedge clk); #1;
        check("s5_idle",  32'(busy), 32'd0);
        check("s5_reads", 32'(ptr_reads - base_ptr + nz_reads - base_nz), 32'd0);

        // Reset while a nonzero beat is stalled
        load_s1();
        push(10'd0, 8'd0, 8'd0); push(10'd1, 8'd5, 8'd6);
        bus.out_ready = 1'b0;
        base_done = done_cnt;
        pulse_start(9'd2);
        found = 1'b0;
        for (int c = 0; c < 20 && !found; c++) begin
            @(posedge clk); #1;
            if (bus.out_valid) found = 1'b1;
        end
        check("s6_hdr_seen", 32'(found), 32'd1);
        bus.out_ready = 1'b1;
        @(posedge clk); #1; bus.out_ready = 1'b0;
        @(posedge clk); #1;
        check("s6_nz_out_valid", 32'(bus.out_valid), 32'd1);
        check("s6_nz_out_addr",  32'(bus.out_nnz_addr), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("s6_abort_valid", 32'(bus.out_valid), 32'd0);
        check("s6_abort_busy",  32'(busy), 32'd0);
        exp_q.delete();
        @(negedge clk); rst_n = 1'b1;
        bus.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("s6_no_done", 32'(done_cnt - base_done), 32'd0);
        check("s6_idle",    32'(busy), 32'd0);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end
endmodule
